// File: rtl/modinv_pkg.sv
// Shared Kyber arithmetic package: modulus, widths, the inversion exponent and
// the sequencer state encoding used by the modular inverse unit.
package kyber_pkg;

  localparam int Q       = 3329;
  localparam int QW      = 12;
  localparam int EXP_INV = Q - 2;
  // 3303 is the inverse of 128 (the Kyber NTT length scale); 256^-1 is 3316.
  localparam int N_INV   = 3303;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/modinv_if.sv
// Start/ready/valid request bus of the modular inverse unit.
interface modinv_if;

  logic                    start;
  logic [kyber_pkg::QW-1:0] a;
  logic                    ready;
  logic                    valid;
  logic [kyber_pkg::QW-1:0] r;
  logic                    err;

  modport master (output start, output a, input ready, input valid, input r, input err);
  modport slave  (input start, input a, output ready, output valid, output r, output err);

endinterface

// File: rtl/modinv_modmul.sv
// Three-stage pipelined modular multiplier: product, Barrett quotient estimate,
// final correction. R is valid three cycles after the operands are applied.
module modmul #(
  parameter int Q = 3329,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] r_o
);

  localparam int     PW = 2 * W;
  localparam longint M  = (longint'(1) << PW) / Q;

  logic [PW-1:0]   p1_q, p2_q;
  logic [W-1:0]    qe_q, r_q;
  logic [2*PW-1:0] pm;
  logic [W-1:0]    qe_d;
  logic [PW-1:0]   t;
  logic [W-1:0]    r_d;

  // The floored Barrett estimate undershoots by at most one, so t < 2Q.
  always_comb begin
    pm   = (2*PW)'(p1_q) * (2*PW)'(M);
    qe_d = W'(pm >> PW);
    t    = p2_q - PW'(qe_q) * PW'(Q);
    r_d  = (t >= PW'(Q)) ? W'(t - PW'(Q)) : W'(t);
  end

  // NOTE: the pipeline is reset too, so a restart after rst never sees stale products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q <= '0;
      p2_q <= '0;
      qe_q <= '0;
      r_q  <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      p1_q <= PW'(a_i) * PW'(b_i);
      p2_q <= p1_q;
      qe_q <= qe_d;
      r_q  <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/modinv.sv
// Fermat modular inverse r = a^EXP mod Q by left-to-right square-and-multiply
// over one shared pipelined modmul; fixed latency regardless of the operand.
module modinv #(
  parameter int             Q     = kyber_pkg::Q,
  parameter int             EW    = kyber_pkg::QW,
  parameter logic [EW-1:0]  EXP   = EW'(kyber_pkg::EXP_INV),
  parameter int             MMLAT = 3
) (
  input  logic     clk,
  input  logic     rst,
  modinv_if.slave  bus
);

  import kyber_pkg::*;

  localparam logic [1:0] WLAST = 2'(MMLAT);

  state_t        state_q, state_d;
  logic [QW-1:0] base_q, base_d;
  logic [QW-1:0] acc_q, acc_d;
  logic [3:0]    bitidx_q, bitidx_d;
  logic          phase_q, phase_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [QW-1:0] r_q, r_d;
  logic          err_q, err_d;
  logic [QW-1:0] mm_a, mm_b, mm_r;

  modmul #(.Q(Q), .W(QW)) u_modmul (
    .clk (clk),
    .rst (rst),
    .a_i (mm_a),
    .b_i (mm_b),
    .r_o (mm_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      acc_q    <= '0;
      bitidx_q <= '0;
      phase_q  <= 1'b0;
      wcnt_q   <= '0;
      r_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      bitidx_q <= bitidx_d;
      phase_q  <= phase_d;
      wcnt_q   <= wcnt_d;
      r_q      <= r_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default on every next-state value keeps this block latch-free.
    state_d  = state_q;
    base_d   = base_q;
    acc_d    = acc_q;
    bitidx_d = bitidx_q;
    phase_d  = phase_q;
    wcnt_d   = wcnt_q;
    r_d      = r_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        base_d   = bus.a;
        acc_d    = bus.a;
        bitidx_d = 4'(EW - 2);
        phase_d  = 1'b0;
        wcnt_d   = '0;
        state_d  = OP;
      end
      OP: begin
        if (wcnt_q == WLAST) begin
          acc_d  = mm_r;
          wcnt_d = '0;
          if (!phase_q && EXP[bitidx_q]) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bitidx_q == '0) begin
              state_d = DONE;
              r_d     = mm_r;
              err_d   = (base_q == '0);
            end else begin
              bitidx_d = bitidx_q - 4'd1;
            end
          end
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mm_a      = acc_q;
    mm_b      = phase_q ? base_q : acc_q;
    bus.ready = (state_q == IDLE);
    bus.valid = (state_q == DONE);
    bus.r     = r_q;
    bus.err   = err_q;
  end

endmodule

// File: tb/tb_modinv.sv
// Directed bench for modinv: latency, handshake, known inverses, a=0,
// busy-time start rejection and mid-run reset.
module tb_modinv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  modinv_if bus ();

  modinv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one request and tracks it to completion; returns the result.
  task automatic run_inv(input logic [11:0] av, input logic exp_err, input string tag,
                         output logic [11:0] got_r);
    int lat, busy;
    @(negedge clk);
    check({tag, " ready_before"}, 32'(bus.ready), 32'd1);
    bus.a = av;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy = bus.ready ? 0 : 1;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (!bus.ready) busy++;
      if (bus.valid) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd80);
    check({tag, " busy_cycles"}, 32'(busy), 32'd81);
    check({tag, " err"}, 32'(bus.err), 32'(exp_err));
    got_r = bus.r;
    @(posedge clk); #1;
    check({tag, " ready_after"}, 32'({bus.ready, bus.valid}), 32'b10);
    check({tag, " r_hold"}, 32'(bus.r), 32'(got_r));
  endtask

  initial begin
    logic [11:0] r;
    logic [11:0] av;
    int valids, vlat;
    logic [11:0] vr;

    bus.start = 1'b0;
    bus.a = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ready/valid", 32'({bus.ready, bus.valid}), 32'b10);
    check("reset r", 32'(bus.r), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);

    run_inv(12'd1, 1'b0, "a1", r);     check("a1 r", 32'(r), 32'd1);
    run_inv(12'd2, 1'b0, "a2", r);     check("a2 r", 32'(r), 32'd1665);
    run_inv(12'd3, 1'b0, "a3", r);     check("a3 r", 32'(r), 32'd1110);
    run_inv(12'd17, 1'b0, "a17", r);   check("a17 r", 32'(r), 32'd1175);
    run_inv(12'd3328, 1'b0, "a3328", r); check("a3328 r", 32'(r), 32'd3328);
    run_inv(12'd128, 1'b0, "a128", r); check("a128 r", 32'(r), 32'(kyber_pkg::N_INV));
    run_inv(12'd256, 1'b0, "a256", r); check("a256 r", 32'(r), 32'd3316);
    run_inv(12'd0, 1'b1, "a0", r);     check("a0 r", 32'(r), 32'd0);
    run_inv(12'd5, 1'b0, "a5", r);     check("a5 r", 32'(r), 32'd666);

    // Spread of operands: the product with the returned inverse must be 1 mod Q.
    for (int i = 0; i < 24; i++) begin
      av = 12'(1 + i * 139);
      run_inv(av, 1'b0, "sweep", r);
      check("sweep a*r mod q", (32'(av) * 32'(r)) % 32'd3329, 32'd1);
    end

    // start with a=7 pulsed at E10 and E40 during an a=2 run must be ignored.
    @(negedge clk);
    bus.a = 12'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    valids = 0; vlat = -1; vr = '0;
    for (int n = 1; n <= 170; n++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        valids++;
        vlat = n;
        vr = bus.r;
      end
      if (n == 9 || n == 39) begin
        bus.a = 12'd7;
        bus.start = 1'b1;
      end else if (n == 10 || n == 40) begin
        bus.start = 1'b0;
      end
    end
    check("busy start valid count", 32'(valids), 32'd1);
    check("busy start latency", 32'(vlat), 32'd80);
    check("busy start r", 32'(vr), 32'd1665);
    check("busy start idle after", 32'({bus.ready, bus.valid}), 32'b10);

    // Reset at E37 of an a=3 run aborts it without a valid pulse.
    @(negedge clk);
    bus.a = 12'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    valids = 0;
    for (int n = 1; n <= 37; n++) begin
      @(posedge clk); #1;
      if (bus.valid) valids++;
    end
    rst = 1'b1;
    #1;
    check("abort reset ready/valid", 32'({bus.ready, bus.valid}), 32'b10);
    check("abort reset r", 32'(bus.r), 32'd0);
    check("abort reset err", 32'(bus.err), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.valid) valids++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (bus.valid) valids++;
    end
    check("abort no valid", 32'(valids), 32'd0);
    check("abort r still 0", 32'(bus.r), 32'd0);
    run_inv(12'd17, 1'b0, "post-reset a17", r);
    check("post-reset a17 r", 32'(r), 32'd1175);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
